// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the program counter, fetches 8-bit instructions over a
// req/ack handshake and holds each one for the control unit until it is consumed.
module inst_fetch_unit #(
    parameter int                     PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = {PC_WIDTH{1'b0}},
    parameter int                     TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  pc_load,
    input  logic [PC_WIDTH-1:0]   pc_load_val,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [7:0]            imem_rdata,
    input  logic                  imem_ack,
    output logic [7:0]            inst,
    output logic                  inst_valid,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic                  fetch_err
);

    localparam int                CW       = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(32'd1);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(32'd1);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [CW-1:0]         wait_cnt;
    logic [CW-1:0]         wait_cnt_next;
    logic [7:0]            inst_next;
    logic [PC_WIDTH-1:0]   inst_pc_next;

    // Next-state, PC, wait-counter and instruction-register update logic.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        wait_cnt_next = wait_cnt;
        inst_next     = inst;
        inst_pc_next  = inst_pc;
        case (state)
            S_REQ: begin
                // A redirect discards any data returned in the same cycle.
                if (pc_load) begin
                    pc_next       = pc_load_val;
                    wait_cnt_next = {CW{1'b0}};
                    state_next    = S_REQ;
                end else if (imem_ack) begin
                    inst_next     = imem_rdata;
                    inst_pc_next  = pc;
                    pc_next       = pc + PC_ONE;
                    wait_cnt_next = {CW{1'b0}};
                    state_next    = S_VALID;
                end else if (wait_cnt == CNT_LAST) begin
                    wait_cnt_next = {CW{1'b0}};
                    state_next    = S_ERR;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_ONE;
                    state_next    = S_REQ;
                end
            end
            S_VALID: begin
                if (pc_load) begin
                    pc_next       = pc_load_val;
                    wait_cnt_next = {CW{1'b0}};
                    state_next    = S_REQ;
                end else if (!stall) begin
                    state_next    = S_REQ;
                end else begin
                    state_next    = S_VALID;
                end
            end
            S_ERR: begin
                wait_cnt_next = {CW{1'b0}};
                state_next    = S_ERR;
            end
            default: begin
                // Unreachable encoding: park in the error state so it is visible.
                wait_cnt_next = {CW{1'b0}};
                state_next    = S_ERR;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            wait_cnt   <= {CW{1'b0}};
            inst       <= 8'h00;
            inst_pc    <= {PC_WIDTH{1'b0}};
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            wait_cnt   <= wait_cnt_next;
            inst       <= inst_next;
            inst_pc    <= inst_pc_next;
            imem_req   <= (state_next == S_REQ);
            inst_valid <= (state_next == S_VALID);
            fetch_err  <= (state_next == S_ERR);
        end
    end

    assign imem_addr = pc;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage directly upstream of the control unit. It holds the program counter and requests 8-bit instructions from instruction memory over a req/ack handshake. Each returned instruction is registered and presented to the control unit with a valid flag; the stage holds it while the decode side stalls. It also supports PC redirects and flags a memory timeout.

Parameters:
PC_WIDTH, 8, width of program counter and imem_addr
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 16, max cycles in S_REQ without imem_ack before error (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-high
stall  input  1  downstream cannot accept instruction this cycle
pc_load  input  1  redirect request (jump/branch)
pc_load_val  input  PC_WIDTH  redirect target
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_WIDTH  fetch address (= pc register)
imem_rdata  input  8  instruction data, valid when imem_ack=1
imem_ack  input  1  memory response for address on imem_addr this cycle
inst  output  8  registered instruction to control unit (opcode = inst[7:4])
inst_valid  output  1  inst holds an unconsumed instruction
inst_pc  output  PC_WIDTH  address inst was fetched from
fetch_err  output  1  sticky memory-timeout flag

Behaviour:
- Reset (sampled at posedge): pc=RESET_PC, inst=8'h00, inst_pc=0, fetch_err=0, wait counter=0, state=S_REQ. The cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC, inst_valid=0.
- Reset mid-operation abandons any outstanding request. Any imem_ack in that cycle is ignored.
- States: S_REQ, S_VALID, S_ERR. Outputs are decoded from registered state only.
  - imem_req = (state==S_REQ)
  - inst_valid = (state==S_VALID)
  - fetch_err = (state==S_ERR)
- S_REQ:
  - On imem_ack=1 (and no pc_load): inst<=imem_rdata, inst_pc<=pc, pc<=pc+1, counter<=0, go to S_VALID.
  - Without ack: counter increments. If counter==TIMEOUT-1 with no ack, go to S_ERR.
- S_VALID:
  - inst and inst_pc are held stable and no request is issued.
  - stall=0: instruction consumed at this edge, go to S_REQ.
  - stall=1: stay.
- S_ERR:
  - imem_req=0 and inst_valid=0.
  - pc_load and imem_ack are ignored. Exit only via reset.
- pc_load (priority below reset, above everything else; applies in S_REQ and S_VALID):
  - Actions: pc<=pc_load_val, counter<=0, state<=S_REQ.
  - imem_ack/imem_rdata in the same cycle are discarded; inst is not updated.
  - A valid but unconsumed instruction is dropped: inst_valid=0 next cycle. inst keeps its old value but is invalid.
  - The next cycle presents imem_addr=pc_load_val with imem_req=1.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH (0xFF -> 0x00 at 8 bits), no flag.
- Latency/throughput:
  - Zero-wait memory: one instruction every 2 cycles (1 cycle S_REQ, 1 cycle S_VALID).
  - Each memory wait cycle adds 1 cycle; each stall cycle adds 1 cycle.
- Memory protocol: the memory must not assert ack when imem_req=0. The unit ignores ack outside S_REQ.
- imem_addr is stable for the whole S_REQ dwell because it changes only on ack, pc_load or reset.

Test Plan:
1. Reset 3 cycles, then release -> imem_req=1, imem_addr=0x00, inst_valid=0, fetch_err=0. Repeated over 5 cycles with no ack after TIMEOUT raised to 32.
2. Zero-wait memory, rdata=addr^0xA5, stall=0, 8 fetches -> inst sequence A5,A4,A7,A6,... with inst_pc 0,1,2,3,...; inst_valid toggles 0/1 every cycle.
3. Memory with 2 wait cycles, stall=1 for 3 cycles after first valid -> inst=0xA5 held 4 cycles, imem_req=0 during stall, then imem_addr=0x01.
4. pc_load=1, pc_load_val=0x40 in the same cycle as imem_ack with rdata=0x3C -> 0x3C never appears as valid; next cycle imem_addr=0x40, inst_valid=0.
5. pc_load to 0xFF, fetch with stall=0 -> inst_pc=0xFF, next imem_addr=0x00.
6. TIMEOUT=4, ack held low -> fetch_err=1 after 4 request cycles, imem_req=0; pc_load to 0x10 ignored; reset -> fetch_err=0, imem_addr=RESET_PC.
